// File: rtl/board_state_pkg.sv
// Shared constants and types for the game-board stage.
// - Grid geometry: N_CELLS, GRID, CELL_W (bits per digit) and VIS_W (bits per visibility code).
// - Flat vector widths: MAP_W for the board and map, VIS_BITS for visibility and cell state.
// - cell_state_e: per-cell status codes.
// - game_state_e: FSM state encodings.
// - cell_index: converts a row/column pair into a flat cell index.
package board_state_pkg;

  localparam int N_CELLS  = 81;
  localparam int GRID     = 9;
  localparam int CELL_W   = 4;
  localparam int VIS_W    = 2;
  localparam int MAP_W    = N_CELLS * CELL_W;  // 324
  localparam int VIS_BITS = N_CELLS * VIS_W;   // 162

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    GIVEN = 2'b01,
    OK    = 2'b10,
    WRONG = 2'b11
  } cell_state_e;

  typedef enum logic [2:0] {
    EMPTY_BOARD = 3'd0,
    LOADING     = 3'd1,
    PLAY        = 3'd2,
    WON         = 3'd3,
    LOST        = 3'd4
  } game_state_e;

  // Flat index i = row*9 + col. Both inputs are 0..8, so the result fits in 7 bits.
  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return (7'(row) * 7'(GRID)) + 7'(col);
  endfunction

endpackage

// File: rtl/board_state_if.sv
// Bundle between the map selector / input logic and the render stage.
// - Inputs to the board:
//   - load: 1-cycle pulse that snapshots the puzzle.
//   - selected_map / selected_vis: the puzzle contents.
//   - btn_up, btn_down, btn_left, btn_right, btn_clear: 1-cycle pulses.
//   - digit_valid with digit: a 1-cycle digit-entry pulse.
// - Outputs from the board:
//   - board and cell_state: flattened per-cell vectors.
//   - cursor_row / cursor_col: the cursor position.
//   - errors: the wrong-entry count.
//   - busy, win, game_over: status levels.
//   - state_dbg: the current FSM state.
// Handshake: every input strobe is a single-cycle valid with no ready. The
// board either acts on it at the sampling edge or ignores it. busy is high
// while the load sweep runs; strobes presented then are dropped and not queued.
interface board_state_if;
  import board_state_pkg::*;

  logic                load;
  logic [MAP_W-1:0]    selected_map;
  logic [VIS_BITS-1:0] selected_vis;
  logic                btn_up;
  logic                btn_down;
  logic                btn_left;
  logic                btn_right;
  logic                digit_valid;
  logic [3:0]          digit;
  logic                btn_clear;

  logic [MAP_W-1:0]    board;
  logic [VIS_BITS-1:0] cell_state;
  logic [3:0]          cursor_row;
  logic [3:0]          cursor_col;
  logic [3:0]          errors;
  logic                busy;
  logic                win;
  logic                game_over;
  game_state_e         state_dbg;

  modport master (
    output load, selected_map, selected_vis, btn_up, btn_down, btn_left,
           btn_right, digit_valid, digit, btn_clear,
    input  board, cell_state, cursor_row, cursor_col, errors, busy, win,
           game_over, state_dbg
  );

  modport slave (
    input  load, selected_map, selected_vis, btn_up, btn_down, btn_left,
           btn_right, digit_valid, digit, btn_clear,
    output board, cell_state, cursor_row, cursor_col, errors, busy, win,
           game_over, state_dbg
  );

endinterface

// File: rtl/board_state_cursor_ctrl.sv
// Player cursor for the 9x9 board.
// Ports:
// - clk, reset: clock and synchronous active-low reset.
// - clear: returns the cursor to (0,0) on a new game.
// - enable: high only when a move may be taken this cycle.
// - btn_up, btn_down, btn_left, btn_right: move pulses.
// - row, col: the current position, each 0..8.
// Only one move is applied per cycle, in priority up > down > left > right.
// A move changes one coordinate and wraps around the edge of the grid.
module cursor_ctrl
  import board_state_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] row,
  output logic [3:0] col
);

  localparam logic [3:0] LAST = 4'(GRID - 1);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (enable) begin
      if (btn_up)
        row <= (row == 4'd0) ? LAST : row - 4'd1;
      else if (btn_down)
        row <= (row == LAST) ? 4'd0 : row + 4'd1;
      else if (btn_left)
        col <= (col == 4'd0) ? LAST : col - 4'd1;
      else if (btn_right)
        col <= (col == LAST) ? 4'd0 : col + 4'd1;
    end
  end

endmodule

// File: rtl/board_state.sv
// Game-board stage downstream of the map selector.
// Ports:
// - clk, reset: clock and synchronous active-low reset.
// - bus (slave): puzzle/load/button inputs in; board, cell_state, cursor,
//   errors, busy/win/game_over and state_dbg out.
// Behaviour:
// - A load pulse snapshots the puzzle, then sweeps the 81 cells one per cycle
//   to build the live board.
// - In PLAY it applies one action per cycle, in priority load > digit > clear > move.
// - It counts solved cells and errors, and ends the game in WON or LOST.
module board_state
  import board_state_pkg::*;
#(
  parameter int MAX_ERRORS = 3
) (
  input  logic          clk,
  input  logic          reset,
  board_state_if.slave  bus
);

  localparam logic [3:0] ERR_LIMIT  = 4'(MAX_ERRORS);
  localparam logic [6:0] LAST_CELL  = 7'(N_CELLS - 1);
  localparam logic [6:0] ALL_SOLVED = 7'(N_CELLS);

  game_state_e         state_q, state_d;

  // Upstream changes every cycle, so only this snapshot is used after load.
  logic [MAP_W-1:0]    shadow_map;
  logic [VIS_BITS-1:0] shadow_vis;

  logic [MAP_W-1:0]    board_q;
  logic [VIS_BITS-1:0] cell_state_q;
  logic [6:0]          sweep_idx;
  logic [6:0]          solved_q, solved_next;
  logic [3:0]          errors_q, errors_next;
  logic [3:0]          cursor_row, cursor_col;

  logic                busy_o, win_o, game_over_o;

  // Decoded actions for the current cycle
  logic [6:0]          cur_idx;
  logic [8:0]          cur_nib;
  logic [7:0]          cur_pair;
  logic [3:0]          cur_sol;
  logic [1:0]          cur_cs;
  logic [8:0]          sw_nib;
  logic [7:0]          sw_pair;
  logic [3:0]          sw_digit;
  logic                sw_given;
  logic                in_play, sweep_active, sweep_last;
  logic                digit_in_range, do_digit, digit_right, do_clear, move_en;

  cursor_ctrl u_cursor (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.load),
    .enable    (move_en),
    .btn_up    (bus.btn_up),
    .btn_down  (bus.btn_down),
    .btn_left  (bus.btn_left),
    .btn_right (bus.btn_right),
    .row       (cursor_row),
    .col       (cursor_col)
  );

  // Action decode and counter updates
  always_comb begin
    cur_idx        = cell_index(cursor_row, cursor_col);
    cur_nib        = {cur_idx, 2'b00};
    cur_pair       = {cur_idx, 1'b0};
    cur_sol        = shadow_map[cur_nib +: CELL_W];
    cur_cs         = cell_state_q[cur_pair +: VIS_W];

    sw_nib         = {sweep_idx, 2'b00};
    sw_pair        = {sweep_idx, 1'b0};
    sw_digit       = shadow_map[sw_nib +: CELL_W];
    sw_given       = |shadow_vis[sw_pair +: VIS_W];

    in_play        = (state_q == PLAY) && !bus.load;
    sweep_active   = (state_q == LOADING) && !bus.load;
    sweep_last     = (sweep_idx == LAST_CELL);

    digit_in_range = (bus.digit >= 4'd1) && (bus.digit <= 4'd9);
    // GIVEN and OK cells are locked against entry; WRONG cells may be re-entered.
    do_digit       = in_play && bus.digit_valid && digit_in_range &&
                     (cur_cs != GIVEN) && (cur_cs != OK);
    digit_right    = (bus.digit == cur_sol);
    do_clear       = in_play && !bus.digit_valid && bus.btn_clear && (cur_cs == WRONG);
    // A pending digit or clear takes this cycle's action slot even when it is ignored.
    move_en        = in_play && !bus.digit_valid && !bus.btn_clear;

    solved_next    = solved_q;
    errors_next    = errors_q;
    if (sweep_active && sw_given)
      solved_next = solved_q + 7'd1;
    if (do_digit) begin
      if (digit_right)
        solved_next = solved_q + 7'd1;
      else if (errors_q < ERR_LIMIT)
        errors_next = errors_q + 4'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= EMPTY_BOARD;
    else
      state_q <= state_d;
  end

  // FSM: next state. Win is tested before loss because a correct entry cannot also add an error.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = LOADING;
    end else begin
      case (state_q)
        LOADING: begin
          if (sweep_last)
            state_d = (solved_next == ALL_SOLVED) ? WON : PLAY;
        end
        PLAY: begin
          if (solved_next == ALL_SOLVED)
            state_d = WON;
          else if (errors_next == ERR_LIMIT)
            state_d = LOST;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy_o      = 1'b0;
    win_o       = 1'b0;
    game_over_o = 1'b0;
    case (state_q)
      LOADING: busy_o      = 1'b1;
      WON:     win_o       = 1'b1;
      LOST:    game_over_o = 1'b1;
      default: ;
    endcase
  end

  // Snapshot, sweep and board datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_map   <= '0;
      shadow_vis   <= '0;
      board_q      <= '0;
      cell_state_q <= '0;
      sweep_idx    <= '0;
      solved_q     <= '0;
      errors_q     <= '0;
    end else if (bus.load) begin
      shadow_map   <= bus.selected_map;
      shadow_vis   <= bus.selected_vis;
      sweep_idx    <= '0;
      solved_q     <= '0;
      errors_q     <= '0;
    end else begin
      if (sweep_active) begin
        board_q[sw_nib +: CELL_W]       <= sw_given ? sw_digit : 4'd0;
        cell_state_q[sw_pair +: VIS_W]  <= sw_given ? GIVEN : EMPTY;
        // Hold at the last cell so the index never points past the vectors.
        if (!sweep_last)
          sweep_idx <= sweep_idx + 7'd1;
      end
      if (do_digit) begin
        board_q[cur_nib +: CELL_W]      <= bus.digit;
        cell_state_q[cur_pair +: VIS_W] <= digit_right ? OK : WRONG;
      end
      if (do_clear) begin
        board_q[cur_nib +: CELL_W]      <= 4'd0;
        cell_state_q[cur_pair +: VIS_W] <= EMPTY;
      end
      solved_q <= solved_next;
      errors_q <= errors_next;
    end
  end

  assign bus.board      = board_q;
  assign bus.cell_state = cell_state_q;
  assign bus.cursor_row = cursor_row;
  assign bus.cursor_col = cursor_col;
  assign bus.errors     = errors_q;
  assign bus.busy       = busy_o;
  assign bus.win        = win_o;
  assign bus.game_over  = game_over_o;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state.
// - The driver tasks issue directed actions.
// - After each action the driver pushes the hand-derived expected observations
//   into exp_q and raises sample_req.
// - The monitor pops and compares every queued entry on the following falling edge.
module tb_board_state;
  import board_state_pkg::*;

  localparam int W = 16;
  localparam logic [3:0] K_CUR   = 4'd0;  // {row, col}
  localparam logic [3:0] K_ERR   = 4'd1;  // errors
  localparam logic [3:0] K_FLAGS = 4'd2;  // {busy, win, game_over}
  localparam logic [3:0] K_CELL  = 4'd3;  // {cell_state, board digit}
  localparam logic [3:0] K_STATE = 4'd4;  // state_dbg

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  board_state_if bus();

  board_state #(.MAX_ERRORS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [3:0]   kind_q[$];
  int           cell_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic         sample_req = 1'b0;

  // Puzzle data
  int                  sol1[N_CELLS];
  int                  sol2[N_CELLS];
  bit                  giv1[N_CELLS];
  logic [MAP_W-1:0]    p1_map, p2_map;
  logic [VIS_BITS-1:0] p1_vis, p2_vis;
  int                  cur_r, cur_c;

  function automatic logic [W-1:0] observe(input logic [3:0] k, input int c);
    case (k)
      K_CUR:   return W'({bus.cursor_row, bus.cursor_col});
      K_ERR:   return W'(bus.errors);
      K_FLAGS: return W'({bus.busy, bus.win, bus.game_over});
      K_CELL:  return W'({bus.cell_state[c*2 +: 2], bus.board[c*4 +: 4]});
      K_STATE: return W'(bus.state_dbg);
      default: return '1;
    endcase
  endfunction

  // Monitor: compare everything queued whenever a sample is presented
  always @(negedge clk) begin
    if (sample_req) begin
      while (exp_q.size() > 0) begin
        logic [W-1:0] e, got;
        logic [3:0]   k;
        int           c;
        string        nm;
        e  = exp_q.pop_front();
        k  = kind_q.pop_front();
        c  = cell_q.pop_front();
        nm = name_q.pop_front();
        got = observe(k, c);
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL %s (cell %0d): got 0x%0h, expected 0x%0h", nm, c, got, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic exp_push(input logic [3:0] k, input int c, input logic [W-1:0] v, input string nm);
    exp_q.push_back(v);
    kind_q.push_back(k);
    cell_q.push_back(c);
    name_q.push_back(nm);
  endtask

  task automatic exp_cell(input int i, input logic [1:0] cs, input logic [3:0] d, input string nm);
    exp_push(K_CELL, i, W'({cs, d}), nm);
  endtask

  task automatic exp_cur(input int r, input int c, input string nm);
    exp_push(K_CUR, 0, W'({4'(r), 4'(c)}), nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    sample_req = 1'b1;
    @(negedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic clr);
    bus.btn_up    = u;
    bus.btn_down  = d;
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_clear = clr;
    step();
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_clear = 1'b0;
  endtask

  task automatic enter(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    step();
    bus.digit_valid = 1'b0;
  endtask

  task automatic do_load(input logic [MAP_W-1:0] m, input logic [VIS_BITS-1:0] v);
    bus.selected_map = m;
    bus.selected_vis = v;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  // Expect busy on each of the 81 sweep cycles, then the given final flags.
  task automatic sweep_check(input bit toggle, input logic [2:0] final_flags);
    for (int k = 0; k < N_CELLS; k++) begin
      if (toggle) begin
        bus.selected_map = ~bus.selected_map;
        bus.selected_vis = ~bus.selected_vis;
      end
      exp_push(K_FLAGS, 0, W'(3'b100), "busy_during_sweep");
      sample();
      step();
    end
    exp_push(K_FLAGS, 0, W'(final_flags), "flags_after_sweep");
    sample();
  endtask

  // Move using only down/right presses, tracking the position locally.
  task automatic goto(input int r, input int c);
    while (cur_r != r) begin
      press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cur_r = (cur_r + 1) % GRID;
    end
    while (cur_c != c) begin
      press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cur_c = (cur_c + 1) % GRID;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Puzzle 1 is a valid Sudoku with 30 givens; puzzle 2 has every cell given.
    for (int i = 0; i < N_CELLS; i++) begin
      int r, c;
      r = i / GRID;
      c = i % GRID;
      sol1[i] = ((r * 3 + r / 3 + c) % 9) + 1;
      sol2[i] = 9 - (i % 9);
      giv1[i] = (i % 3 == 0) || (i == 1) || (i == 2) || (i == 4);
      p1_map[i*4 +: 4] = 4'(sol1[i]);
      p1_vis[i*2 +: 2] = giv1[i] ? 2'b01 : 2'b00;
      p2_map[i*4 +: 4] = 4'(sol2[i]);
      p2_vis[i*2 +: 2] = 2'b11;
    end

    bus.load = 1'b0;
    bus.selected_map = '0;
    bus.selected_vis = '0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_clear = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit = 4'd0;

    // Reset held low for two edges
    reset = 1'b0;
    step();
    step();
    exp_cur(0, 0, "reset_cursor");
    exp_push(K_ERR, 0, W'(4'd0), "reset_errors");
    exp_push(K_FLAGS, 0, W'(3'b000), "reset_flags");
    exp_push(K_STATE, 0, W'(EMPTY_BOARD), "reset_state");
    exp_cell(0, EMPTY, 4'd0, "reset_cell");
    exp_cell(80, EMPTY, 4'd0, "reset_cell");
    sample();
    reset = 1'b1;

    // Load puzzle 1 while the upstream vectors toggle every cycle
    do_load(p1_map, p1_vis);
    sweep_check(1'b1, 3'b000);
    exp_cur(0, 0, "load_cursor");
    exp_push(K_ERR, 0, W'(4'd0), "load_errors");
    exp_push(K_STATE, 0, W'(PLAY), "load_state");
    for (int i = 0; i < N_CELLS; i++)
      exp_cell(i, giv1[i] ? GIVEN : EMPTY, giv1[i] ? 4'(sol1[i]) : 4'd0, "snapshot_cell");
    sample();

    // Cursor moves and wrap-around
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); exp_cur(0, 8, "left_wrap");   sample();
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); exp_cur(0, 0, "right_wrap");  sample();
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); exp_cur(8, 0, "up_wrap");     sample();
    press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); exp_cur(7, 0, "up_over_left"); sample();
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); exp_cur(8, 0, "down");        sample();
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); exp_cur(0, 0, "down_wrap");   sample();
    cur_r = 0;
    cur_c = 0;

    // Digit entry on hidden cell (1,1), solution 5
    goto(1, 1);
    enter(4'd3);
    exp_cell(10, WRONG, 4'd3, "wrong_entry");
    exp_push(K_ERR, 0, W'(4'd1), "wrong_errors");
    sample();
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); exp_cell(10, EMPTY, 4'd0, "clear_wrong"); sample();
    enter(4'd5); exp_cell(10, OK, 4'd5, "right_entry"); exp_push(K_ERR, 0, W'(4'd1), "right_errors"); sample();
    enter(4'd7); exp_cell(10, OK, 4'd5, "ok_locked"); exp_push(K_ERR, 0, W'(4'd1), "ok_locked_errors"); sample();
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); exp_cell(10, OK, 4'd5, "clear_ok"); sample();

    // Given cell (0,0) is locked
    goto(0, 0);
    enter(4'd9); exp_cell(0, GIVEN, 4'd1, "given_locked"); exp_push(K_ERR, 0, W'(4'd1), "given_errors"); sample();
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); exp_cell(0, GIVEN, 4'd1, "clear_given"); sample();

    // Out-of-range digits, then run out of errors on (0,5), solution 6
    goto(0, 5);
    enter(4'd0);  exp_cell(5, EMPTY, 4'd0, "digit_zero");  sample();
    enter(4'd10); exp_cell(5, EMPTY, 4'd0, "digit_ten");   exp_push(K_ERR, 0, W'(4'd1), "bad_digit_errors"); sample();
    enter(4'd1);
    exp_cell(5, WRONG, 4'd1, "second_wrong");
    exp_push(K_ERR, 0, W'(4'd2), "second_errors");
    exp_push(K_FLAGS, 0, W'(3'b000), "not_lost_yet");
    sample();
    enter(4'd2);
    exp_cell(5, WRONG, 4'd2, "rewrite_wrong");
    exp_push(K_ERR, 0, W'(4'd3), "lost_errors");
    exp_push(K_FLAGS, 0, W'(3'b001), "lost_flags");
    exp_push(K_STATE, 0, W'(LOST), "lost_state");
    sample();
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); exp_cur(0, 5, "lost_frozen_cursor"); sample();
    enter(4'd6); exp_cell(5, WRONG, 4'd2, "lost_frozen_cell"); exp_push(K_ERR, 0, W'(4'd3), "lost_frozen_errors"); sample();
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); exp_cell(5, WRONG, 4'd2, "lost_frozen_clear"); sample();

    // Reload: game_over drops and busy rises immediately
    do_load(p1_map, p1_vis);
    sweep_check(1'b0, 3'b000);
    exp_cur(0, 0, "reload_cursor");
    exp_push(K_ERR, 0, W'(4'd0), "reload_errors");
    exp_cell(5, EMPTY, 4'd0, "reload_cell");
    sample();
    cur_r = 0;
    cur_c = 0;

    // Solve every hidden cell; the last one is cell 80
    for (int i = 0; i < N_CELLS; i++) begin
      if (!giv1[i]) begin
        goto(i / GRID, i % GRID);
        if (i == N_CELLS - 1) begin
          exp_push(K_FLAGS, 0, W'(3'b000), "before_last_entry");
          sample();
        end
        enter(4'(sol1[i]));
      end
    end
    exp_cell(80, OK, 4'(sol1[80]), "last_entry");
    exp_push(K_FLAGS, 0, W'(3'b010), "win_flags");
    exp_push(K_STATE, 0, W'(WON), "win_state");
    exp_push(K_ERR, 0, W'(4'd0), "win_errors");
    sample();
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); exp_cur(8, 8, "won_frozen_cursor"); sample();

    // Mid-sweep reload with a fully given puzzle goes straight to WON
    do_load(p1_map, p1_vis);
    repeat (20) step();
    do_load(p2_map, p2_vis);
    for (int k = 0; k < N_CELLS; k++) begin
      exp_push(K_FLAGS, 0, W'(3'b100), "busy_restart");
      if (k == 1) begin
        exp_cell(0, GIVEN, 4'd9, "restart_cell0");
        exp_cell(5, EMPTY, 4'd0, "restart_cell5_old");
        exp_cell(50, OK, 4'(sol1[50]), "restart_cell50_old");
      end
      sample();
      step();
    end
    exp_push(K_FLAGS, 0, W'(3'b010), "all_given_win");
    exp_push(K_STATE, 0, W'(WON), "all_given_state");
    exp_cell(0, GIVEN, 4'(sol2[0]), "all_given_cell");
    exp_cell(40, GIVEN, 4'(sol2[40]), "all_given_cell");
    exp_cell(80, GIVEN, 4'(sol2[80]), "all_given_cell");
    sample();

    // Every queued expectation must have been consumed
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
